// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle FETCH/EXECUTE/MEM/HALT CPU with busywait memories; define CPU_PERF_COUNTERS_EN for retire/stall counters
module cpu_multicycle #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 8,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic [PC_WIDTH-1:0]   PC,
    output logic                  INSTR_READ,
    input  logic [31:0]           INSTRUCTION,
    input  logic                  INSTR_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [DATA_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT,
`ifdef CPU_PERF_COUNTERS_EN
    output logic [31:0]           INSTR_RETIRED,
    output logic [31:0]           STALL_CYCLES,
`endif
    output logic                  HALTED
);
    localparam int IW = $clog2(REG_COUNT);
    typedef enum logic [1:0] {FETCH, EXECUTE, MEM, HALT} state_t;
    state_t state;
    logic [31:0] ir;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [7:0] opcode, imm;
    logic [IW-1:0] rd, rs1, rs2;
    logic [DATA_WIDTH-1:0] op_a, op_b, imm_x, alu, mem_addr;
    logic [PC_WIDTH-1:0] pc_inc, pc_br;
    logic valid, wr_en, taken, is_load, is_store;
    logic unused_bits;
    assign opcode = ir[31:24];
    assign imm = ir[7:0];
    assign rd = ir[16 +: IW];
    assign rs1 = ir[8 +: IW];
    assign rs2 = ir[0 +: IW];
    assign unused_bits = ^ir[15:8];
    assign op_a = regs[rs1];
    assign op_b = regs[rs2];
    assign imm_x = DATA_WIDTH'($signed(imm));
    assign pc_inc = PC + PC_WIDTH'(4);
    assign pc_br = pc_inc + (PC_WIDTH'($signed(ir[23:16])) << 2);
    // shifts by imm >= DATA_WIDTH fall out naturally as 0 / sign fill
    always_comb begin
        alu = '0;
        wr_en = 1'b0;
        taken = 1'b0;
        is_load = 1'b0;
        is_store = 1'b0;
        valid = 1'b1;
        mem_addr = imm_x;
        case (opcode)
            8'h00: begin alu = imm_x; wr_en = 1'b1; end
            8'h01: begin alu = op_b; wr_en = 1'b1; end
            8'h02: begin alu = op_a + op_b; wr_en = 1'b1; end
            8'h03: begin alu = op_a - op_b; wr_en = 1'b1; end
            8'h04: begin alu = op_a & op_b; wr_en = 1'b1; end
            8'h05: begin alu = op_a | op_b; wr_en = 1'b1; end
            8'h06: taken = 1'b1;
            8'h07: taken = op_a == op_b;
            8'h08: begin is_load = 1'b1; mem_addr = op_b; end
            8'h09: is_load = 1'b1;
            8'h0A: begin is_store = 1'b1; mem_addr = op_b; end
            8'h0B: is_store = 1'b1;
            8'h0C: taken = op_a != op_b;
            8'h0D: begin alu = op_a << imm; wr_en = 1'b1; end
            8'h0E: begin alu = op_a >> imm; wr_en = 1'b1; end
            8'h0F: begin alu = $signed(op_a) >>> imm; wr_en = 1'b1; end
            default: valid = 1'b0;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= FETCH;
            PC <= '0;
            ir <= '0;
            regs <= '{default: '0};
            INSTR_READ <= 1'b1;
            MEM_READ <= 1'b0;
            MEM_WRITE <= 1'b0;
            MEM_ADDRESS <= '0;
            MEM_WRITEDATA <= '0;
            HALTED <= 1'b0;
        end else begin
            case (state)
                FETCH: if (!INSTR_BUSYWAIT) begin
                    ir <= INSTRUCTION;
                    INSTR_READ <= 1'b0;
                    state <= EXECUTE;
                end
                EXECUTE: if (!valid) begin
                    HALTED <= 1'b1;
                    state <= HALT;
                end else if (is_load || is_store) begin
                    MEM_ADDRESS <= mem_addr;
                    MEM_WRITEDATA <= op_a;
                    MEM_READ <= is_load;
                    MEM_WRITE <= is_store;
                    state <= MEM;
                end else begin
                    if (wr_en) regs[rd] <= alu;
                    PC <= taken ? pc_br : pc_inc;
                    INSTR_READ <= 1'b1;
                    state <= FETCH;
                end
                MEM: if (!MEM_BUSYWAIT) begin
                    if (MEM_READ) regs[rd] <= MEM_READDATA;
                    PC <= pc_inc;
                    MEM_READ <= 1'b0;
                    MEM_WRITE <= 1'b0;
                    INSTR_READ <= 1'b1;
                    state <= FETCH;
                end
                default: ;
            endcase
        end
    end
`ifdef CPU_PERF_COUNTERS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            INSTR_RETIRED <= '0;
            STALL_CYCLES <= '0;
        end else begin
            if ((state == EXECUTE && valid && !is_load && !is_store) || (state == MEM && !MEM_BUSYWAIT))
                INSTR_RETIRED <= INSTR_RETIRED + 32'd1;
            if ((state == FETCH && INSTR_BUSYWAIT) || (state == MEM && MEM_BUSYWAIT))
                STALL_CYCLES <= STALL_CYCLES + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed programs on an 8-bit and a 16-bit instance, checked against hand-computed values
module tb_cpu_multicycle;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic rst_a, rst_b, ibusy, dbusy, sel;
    logic [15:0] rdata;
    logic [31:0] imem_a [64];
    logic [31:0] imem_b [64];
    logic [31:0] pc_a, pc_b, instr_a, instr_b;
    logic ir_a, ir_b, mr_a, mr_b, mw_a, mw_b, halted_a, halted_b;
    logic [7:0] ma_a, mwd_a;
    logic [15:0] ma_b, mwd_b;
`ifdef CPU_PERF_COUNTERS_EN
    logic [31:0] ret_a, stall_a, ret_b, stall_b;
`endif
    int n_checks = 0;
    int n_fail = 0;
    assign instr_a = imem_a[pc_a[7:2]];
    assign instr_b = imem_b[pc_b[7:2]];

    cpu_multicycle u_dut_a (
        .CLK(CLK), .RESET(rst_a), .PC(pc_a), .INSTR_READ(ir_a), .INSTRUCTION(instr_a),
        .INSTR_BUSYWAIT(ibusy), .MEM_READ(mr_a), .MEM_WRITE(mw_a), .MEM_ADDRESS(ma_a),
        .MEM_WRITEDATA(mwd_a), .MEM_READDATA(rdata[7:0]), .MEM_BUSYWAIT(dbusy),
`ifdef CPU_PERF_COUNTERS_EN
        .INSTR_RETIRED(ret_a), .STALL_CYCLES(stall_a),
`endif
        .HALTED(halted_a)
    );

    cpu_multicycle #(.DATA_WIDTH(16)) u_dut_b (
        .CLK(CLK), .RESET(rst_b), .PC(pc_b), .INSTR_READ(ir_b), .INSTRUCTION(instr_b),
        .INSTR_BUSYWAIT(ibusy), .MEM_READ(mr_b), .MEM_WRITE(mw_b), .MEM_ADDRESS(ma_b),
        .MEM_WRITEDATA(mwd_b), .MEM_READDATA(rdata), .MEM_BUSYWAIT(dbusy),
`ifdef CPU_PERF_COUNTERS_EN
        .INSTR_RETIRED(ret_b), .STALL_CYCLES(stall_b),
`endif
        .HALTED(halted_b)
    );

    logic cur_mw;
    logic [31:0] cur_ma, cur_mwd;
    assign cur_mw = sel ? mw_b : mw_a;
    assign cur_ma = sel ? 32'(ma_b) : 32'(ma_a);
    assign cur_mwd = sel ? 32'(mwd_b) : 32'(mwd_a);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_store(input string tag, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!cur_mw && n < 30) begin
            tick(1);
            n++;
        end
        check({tag, "_seen"}, 32'(cur_mw), 32'd1);
        check({tag, "_addr"}, cur_ma, a);
        check({tag, "_data"}, cur_mwd, d);
        tick(1);
    endtask

    initial begin
        int mem_seen;
        imem_a = '{default: 32'hFF000000};
        imem_b = '{default: 32'hFF000000};
        imem_a[0] = 32'h00010005;  imem_a[1] = 32'h000200FD;  imem_a[2] = 32'h02030102;
        imem_a[3] = 32'h0B000120;  imem_a[4] = 32'h07FE0101;  imem_a[5] = 32'h0A000301;
        imem_a[6] = 32'h03040102;  imem_a[7] = 32'h05050102;  imem_a[8] = 32'h04060102;
        imem_a[9] = 32'h0B000430;  imem_a[10] = 32'h0B000531; imem_a[11] = 32'h0B000632;
        imem_a[12] = 32'h09070040; imem_a[13] = 32'h01000007; imem_a[14] = 32'h0A000000;
        imem_a[15] = 32'h06010000; imem_a[16] = 32'hFF000000; imem_a[17] = 32'h00010080;
        imem_a[18] = 32'h0F020103; imem_a[19] = 32'h0E030109; imem_a[20] = 32'h0F040108;
        imem_a[21] = 32'h0D050201; imem_a[22] = 32'h0B000250; imem_a[23] = 32'h0B000351;
        imem_a[24] = 32'h0B000452; imem_a[25] = 32'h0B000553; imem_a[26] = 32'h02020202;
        imem_a[27] = 32'h0B000254; imem_a[28] = 32'h08060004; imem_a[29] = 32'h0B000655;
        imem_a[30] = 32'hFF000000;
        imem_b[0] = 32'h00010080;  imem_b[1] = 32'h0F020110;  imem_b[2] = 32'h0D030104;
        imem_b[3] = 32'h0B000210;  imem_b[4] = 32'h0B000380;  imem_b[5] = 32'h0E04010F;
        imem_b[6] = 32'h0B000411;  imem_b[7] = 32'hFF000000;
        sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1; ibusy = 1'b0; dbusy = 1'b0; rdata = 16'h00A5;
        tick(2);
        check("rst_pc", pc_a, 32'h0);
        check("rst_iread", 32'(ir_a), 32'd1);
        check("rst_mreq", {30'd0, mr_a, mw_a}, 32'd0);
        check("rst_halted", 32'(halted_a), 32'd0);
        rst_a = 1'b0;
        mem_seen = 0;
        repeat (6) begin
            tick(1);
            if (mr_a || mw_a) mem_seen++;
        end
        check("alu_no_mem", 32'(mem_seen), 32'd0);
        check("alu_pc", pc_a, 32'h0C);
        dbusy = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            check("swi_wr", 32'(mw_a), 32'd1);
            check("swi_addr", 32'(ma_a), 32'h20);
            check("swi_data", 32'(mwd_a), 32'h05);
            check("swi_pc_hold", pc_a, 32'h0C);
            if (i == 3) dbusy = 1'b0;
            tick(1);
        end
        check("swi_wr_drop", 32'(mw_a), 32'd0);
        check("swi_pc", pc_a, 32'h10);
        tick(2);
        check("beq_pc", pc_a, 32'h0C);
        imem_a[4] = 32'h0CFE0101;
        tick(5);
        check("bne_pc", pc_a, 32'h14);
        ibusy = 1'b1;
        tick(3);
        check("ibusy_pc", pc_a, 32'h14);
        check("ibusy_iread", 32'(ir_a), 32'd1);
        ibusy = 1'b0;
        expect_store("add", 32'h05, 32'h02);
        expect_store("sub", 32'h30, 32'h08);
        expect_store("or", 32'h31, 32'hFD);
        expect_store("and", 32'h32, 32'h05);
        expect_store("lwi_mov", 32'hA5, 32'hA5);
        rdata = 16'h003C;
        expect_store("sra8", 32'h50, 32'hF0);
        expect_store("srl8_big", 32'h51, 32'h00);
        expect_store("sra8_big", 32'h52, 32'hFF);
        expect_store("sll8", 32'h53, 32'hE0);
        expect_store("add_wrap", 32'h54, 32'hE0);
        expect_store("lwd", 32'h55, 32'h3C);
        tick(3);
        check("halt_flag", 32'(halted_a), 32'd1);
        check("halt_iread", 32'(ir_a), 32'd0);
        check("halt_pc", pc_a, 32'h78);
`ifdef CPU_PERF_COUNTERS_EN
        check("perf_retired", ret_a, 32'd31);
        check("perf_stalls", stall_a, 32'd6);
        tick(3);
        check("perf_retired_halt", ret_a, 32'd31);
`endif
        imem_a[3] = 32'h09070040;
        dbusy = 1'b1;
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        tick(8);
        check("lwi_rd", 32'(mr_a), 32'd1);
        check("lwi_addr", 32'(ma_a), 32'h40);
        tick(2);
        check("lwi_hold", 32'(mr_a), 32'd1);
        check("lwi_pc_hold", pc_a, 32'h0C);
        rst_a = 1'b1;
        tick(1);
        check("midrst_mrd", 32'(mr_a), 32'd0);
        check("midrst_pc", pc_a, 32'h0);
        check("midrst_iread", 32'(ir_a), 32'd1);
        rst_a = 1'b0;
        dbusy = 1'b0;
        tick(2);
        check("midrst_restart_pc", pc_a, 32'h04);
        sel = 1'b1;
        rst_b = 1'b0;
        expect_store("sra16", 32'h0010, 32'hFFFF);
        expect_store("sll16", 32'hFF80, 32'hF800);
        expect_store("srl16", 32'h0011, 32'h0001);
        tick(3);
        check("halt16", 32'(halted_b), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
